// File: rtl/als_controlador_sequenciador_if.sv
// als_controlador_sequenciador_if: run/opcode inputs and SAP-1 control word, step and status outputs.
interface als_controlador_sequenciador_if;
    logic       run;
    logic [3:0] opcode;
    logic       cp;
    logic       ep;
    logic       n_lm;
    logic       n_ce;
    logic       n_li;
    logic       n_ei;
    logic       n_la;
    logic       ea;
    logic       su;
    logic       eu;
    logic       n_lb;
    logic       n_lo;
    logic [5:0] t_state;
    logic       halted;
    logic       instr_done;

    modport master (
        output run, opcode,
        input  cp, ep, n_lm, n_ce, n_li, n_ei, n_la, ea, su, eu, n_lb, n_lo,
        input  t_state, halted, instr_done
    );

    modport slave (
        input  run, opcode,
        output cp, ep, n_lm, n_ce, n_li, n_ei, n_la, ea, su, eu, n_lb, n_lo,
        output t_state, halted, instr_done
    );
endinterface

// File: rtl/als_controlador_sequenciador.sv
// als_controlador_sequenciador: SAP-1 six-step ring counter with opcode decode into the 12-bit control word.
module als_controlador_sequenciador (
    input logic clk,
    input logic n_rst,
    als_controlador_sequenciador_if.slave bus
);
    typedef enum logic [2:0] {IDLE, S1, S2, S3, S4, S5, S6, HALT} state_t;

    state_t state;
    logic   lda, add, sub, out, mem, alu;

    always_ff @(posedge clk)
        if (!n_rst) state <= IDLE;
        else case (state)
            IDLE:    state <= bus.run ? S1 : IDLE;
            S1:      state <= S2;
            S2:      state <= S3;
            S3:      state <= S4;
            S4:      state <= (bus.opcode == 4'b1111) ? HALT : S5;
            S5:      state <= S6;
            S6:      state <= bus.run ? S1 : IDLE;
            default: state <= HALT;
        endcase

    assign lda = bus.opcode == 4'b0000;
    assign add = bus.opcode == 4'b0001;
    assign sub = bus.opcode == 4'b0010;
    assign out = bus.opcode == 4'b1110;
    assign alu = add | sub;
    assign mem = lda | alu;

    // Each strobe is gated by its exact step, so only one W-bus driver can ever be live.
    assign bus.cp   = state == S2;
    assign bus.ep   = state == S1;
    assign bus.n_lm = !(state == S1 || (state == S4 && mem));
    assign bus.n_ce = !(state == S3 || (state == S5 && mem));
    assign bus.n_li = !(state == S3);
    assign bus.n_ei = !(state == S4 && mem);
    assign bus.n_la = !((state == S5 && lda) || (state == S6 && alu));
    assign bus.ea   = state == S4 && out;
    assign bus.su   = state == S6 && sub;
    assign bus.eu   = state == S6 && alu;
    assign bus.n_lb = !(state == S5 && alu);
    assign bus.n_lo = !(state == S4 && out);

    assign bus.t_state    = {state == S6, state == S5, state == S4, state == S3, state == S2, state == S1};
    assign bus.halted     = state == HALT;
    assign bus.instr_done = state == S6;
endmodule
